// File: rtl/demux_router_pkg.sv
// Shared constants and select decoding for the registered demux router.
// sel_decode works on a 16-bit view so one function serves every N up to 16.
package demux_router_pkg;

    localparam int MODE_BIN     = 0;
    localparam int MODE_ONEHOT  = 1;
    localparam int CNTW_DEFAULT = 8;
    localparam int NMAX         = 16;

    // Returns {sel_ok, dest}; dest is one-hot over NMAX channels.
    function automatic logic [NMAX:0] sel_decode(input logic [NMAX-1:0] sel,
                                                 input int unsigned      n,
                                                 input int unsigned      mode);
        logic [NMAX-1:0] dest;
        logic            ok;
        dest = '0;
        ok   = 1'b0;
        if (mode == MODE_BIN) begin
            if (32'(sel) < n) begin
                ok             = 1'b1;
                dest[sel[3:0]] = 1'b1;
            end
        end else begin
            ok   = ($countones(sel) == 1);
            dest = sel;
        end
        return {ok, dest};
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register for a single output channel.
// A load in the same cycle as a consume wins, so the channel sustains one word per cycle.
module demux_chan_reg #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        // Data is never cleared on consume; the last word stays latched.
        if (load_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-N demultiplexer with per-channel valid/ready holding registers.
// Invalid selects are always drained, flagged for one cycle and counted (saturating).
module demux_router
    import demux_router_pkg::*;
#(
    parameter  int W    = 1,
    parameter  int N    = 4,
    parameter  int MODE = MODE_ONEHOT,
    parameter  int CNTW = CNTW_DEFAULT,
    localparam int SELW = (MODE == MODE_ONEHOT) ? N : $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    SW,
    input  logic [SELW-1:0] Sel,
    output logic [N*W-1:0]  O,
    output logic [N-1:0]    o_valid,
    input  logic [N-1:0]    o_ready,
    output logic            err,
    output logic [CNTW-1:0] err_cnt
);

    logic [NMAX:0]   dec;
    logic            sel_ok;
    logic [NMAX-1:0] dest;
    logic [NMAX-1:0] ov_ext;
    logic [NMAX-1:0] or_ext;
    logic            accept;

    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign dec    = sel_decode(NMAX'(Sel), N, MODE);
    assign sel_ok = dec[NMAX];
    assign dest   = dec[NMAX-1:0];
    assign ov_ext = NMAX'(o_valid);
    assign or_ext = NMAX'(o_ready);

    // dest is zero above N for any valid select, so the wide reduction only sees real channels.
    assign in_ready = !sel_ok || (|(dest & (~ov_ext | or_ext)));
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan_reg #(.W(W)) u_chan (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .load_i  (accept && sel_ok && dest[k]),
            .data_i  (SW),
            .ready_i (o_ready[k]),
            .data_o  (O[k*W +: W]),
            .valid_o (o_valid[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        err_d = accept && !sel_ok;
        cnt_d = cnt_q;
        if (err_d && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: three configurations driven in parallel and compared
// every cycle against a channel-array model, plus directed boundary cases.
module tb_demux_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv   [3];
    logic [15:0] isel [3];
    logic [7:0]  isw  [3];
    logic [3:0]  ordy [3];

    wire  [3:0]  oA;
    wire  [31:0] oB;
    wire  [23:0] oC;
    wire  [3:0]  vA, vB;
    wire  [2:0]  vC;
    wire         rA, rB, rC, eA, eB, eC;
    wire  [7:0]  cA, cB;
    wire  [1:0]  cC;

    demux_router #(.W(1), .N(4), .MODE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rA),
        .SW(isw[0][0:0]), .Sel(isel[0][3:0]), .O(oA), .o_valid(vA),
        .o_ready(ordy[0]), .err(eA), .err_cnt(cA));

    demux_router #(.W(8), .N(4), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rB),
        .SW(isw[1]), .Sel(isel[1][1:0]), .O(oB), .o_valid(vB),
        .o_ready(ordy[1]), .err(eB), .err_cnt(cB));

    demux_router #(.W(8), .N(3), .MODE(0), .CNTW(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rC),
        .SW(isw[2]), .Sel(isel[2][1:0]), .O(oC), .o_valid(vC),
        .o_ready(ordy[2][2:0]), .err(eC), .err_cnt(cC));

    logic [31:0] dO [3];
    logic [3:0]  dv [3];
    logic        dr [3];
    logic        de [3];
    logic [7:0]  dc [3];

    assign dO[0] = {28'b0, oA};
    assign dO[1] = oB;
    assign dO[2] = {8'b0, oC};
    assign dv[0] = vA;
    assign dv[1] = vB;
    assign dv[2] = {1'b0, vC};
    assign dr[0] = rA;
    assign dr[1] = rB;
    assign dr[2] = rC;
    assign de[0] = eA;
    assign de[1] = eB;
    assign de[2] = eC;
    assign dc[0] = cA;
    assign dc[1] = cB;
    assign dc[2] = {6'b0, cC};

    int P_W    [3] = '{1, 8, 8};
    int P_N    [3] = '{4, 4, 3};
    int P_MODE [3] = '{1, 0, 0};
    int P_SELW [3] = '{4, 2, 2};
    int P_CMAX [3] = '{255, 255, 3};

    logic [7:0] mO   [3][4];
    logic       mv   [3][4];
    logic       merr [3];
    int         mcnt [3];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic decode(input int i, output logic ok, output int d);
        ok = 1'b0;
        d  = 0;
        if (P_MODE[i] == 1) begin
            if ($countones(isel[i]) == 1) begin
                ok = 1'b1;
                for (int b = 0; b < 16; b++) if (isel[i][b]) d = b;
            end
        end else if (int'(isel[i]) < P_N[i]) begin
            ok = 1'b1;
            d  = int'(isel[i]);
        end
    endtask

    task automatic step();
        logic ok  [3];
        int   d   [3];
        logic acc [3];
        logic er;
        logic [31:0] msk;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            decode(i, ok[i], d[i]);
            er = !ok[i] || !mv[i][d[i]] || ordy[i][d[i]];
            if (rst_n) chk($sformatf("in_ready[%0d]", i), 32'(dr[i]), 32'(er));
            acc[i] = iv[i] && er;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    mO[i][k] = '0;
                    mv[i][k] = 1'b0;
                end
                merr[i] = 1'b0;
                mcnt[i] = 0;
            end else begin
                for (int k = 0; k < 4; k++) if (mv[i][k] && ordy[i][k]) mv[i][k] = 1'b0;
                if (acc[i] && ok[i]) begin
                    mO[i][d[i]] = isw[i];
                    mv[i][d[i]] = 1'b1;
                end
                merr[i] = acc[i] && !ok[i];
                if (merr[i] && mcnt[i] < P_CMAX[i]) mcnt[i]++;
            end
            msk = (32'd1 << P_W[i]) - 1;
            for (int k = 0; k < P_N[i]; k++) begin
                chk($sformatf("O[%0d][%0d]", i, k), (dO[i] >> (k * P_W[i])) & msk, 32'(mO[i][k]) & msk);
                chk($sformatf("o_valid[%0d][%0d]", i, k), 32'(dv[i][k]), 32'(mv[i][k]));
            end
            chk($sformatf("err[%0d]", i), 32'(de[i]), 32'(merr[i]));
            chk($sformatf("err_cnt[%0d]", i), 32'(dc[i]), 32'(mcnt[i]));
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                mO[i][k] = '0;
                mv[i][k] = 1'b0;
            end
            merr[i] = 1'b0;
            mcnt[i] = 0;
            iv[i]   = 1'b1;
            isel[i] = 16'd1;
            isw[i]  = 8'hFF;
            ordy[i] = 4'h0;
        end
        rst_n = 1'b0;

        // Reset held two cycles with words offered.
        step();
        step();
        chk("rst_O_a", dO[0], 32'h0);
        chk("rst_valid_b", 32'(dv[1]), 32'h0);
        chk("rst_cnt_c", 32'(dc[2]), 32'h0);
        rst_n = 1'b1;
        idle();

        // One-hot sweep fills all four channels of the W=1 router.
        for (int j = 0; j < 4; j++) begin
            iv[0]   = 1'b1;
            isel[0] = 16'(1 << j);
            isw[0]  = 8'h01;
            step();
        end
        chk("sweep_O", dO[0], 32'hF);
        chk("sweep_valid", 32'(dv[0]), 32'hF);
        isel[0] = 16'h1;
        step();
        chk("full_refused", 32'(dv[0]), 32'hF);

        // Zero and multi-bit one-hot selects are dropped and counted.
        isel[0] = 16'h0;
        step();
        chk("inv0_err", 32'(de[0]), 32'h1);
        isel[0] = 16'h3;
        step();
        chk("inv1_err", 32'(de[0]), 32'h1);
        chk("inv_cnt", 32'(dc[0]), 32'h2);
        chk("inv_O_kept", dO[0], 32'hF);
        idle();
        step();
        chk("err_one_cycle", 32'(de[0]), 32'h0);

        // Binary mode with all consumers ready.
        ordy[1] = 4'hF;
        iv[1]   = 1'b1;
        isel[1] = 16'd2;
        isw[1]  = 8'hA5;
        step();
        chk("bin_O2", dO[1][23:16], 32'hA5);
        chk("bin_valid", 32'(dv[1]), 32'h4);
        isel[1] = 16'd3;
        for (int j = 0; j < 4; j++) begin
            isw[1] = 8'(8'h10 + j);
            step();
        end
        chk("bin_stream_O3", dO[1][31:24], 32'h13);

        // N=3 binary: index 3 is invalid; counter saturates at 3.
        idle();
        iv[2]   = 1'b1;
        isel[2] = 16'd3;
        step();
        chk("n3_err", 32'(de[2]), 32'h1);
        for (int j = 0; j < 4; j++) step();
        chk("sat_cnt", 32'(dc[2]), 32'h3);
        step();
        chk("sat_hold", 32'(dc[2]), 32'h3);

        // Load and consume on the same channel in one cycle.
        idle();
        ordy[1] = 4'h0;
        iv[1]   = 1'b1;
        isel[1] = 16'd1;
        isw[1]  = 8'h11;
        step();
        ordy[1] = 4'hF;
        isw[1]  = 8'h3C;
        step();
        chk("acc_cons_O1", dO[1][15:8], 32'h3C);
        chk("acc_cons_v1", 32'(dv[1][1]), 32'h1);
        rst_n  = 1'b0;
        isw[1] = 8'h77;
        step();
        chk("rst_over_acc_O", dO[1], 32'h0);
        chk("rst_over_acc_v", 32'(dv[1]), 32'h0);
        rst_n = 1'b1;

        // Randomised traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 3; i++) begin
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = 4'($urandom);
                isw[i]  = 8'($urandom);
                if (P_MODE[i] == 1 && $urandom_range(0, 3) != 0)
                    isel[i] = 16'(1 << $urandom_range(0, P_N[i] - 1));
                else
                    isel[i] = 16'($urandom) & 16'((1 << P_SELW[i]) - 1);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
